cnna_mac_pipe: RTL and testbench

CNNA_MAC_PIPE -- requirements
Module: cnna_mac_pipe

---
 rtl/cnna_mac_pipe.sv | 169 ++++++++++++++++
 tb/tb_cnna_mac_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnna_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with valid-ready handshake.
// Products travel NUM_STAGE tagged stages, then retire into a registered output or running sum.
module cnna_mac_pipe #(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 13,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 acc_en,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 ovf
);

  localparam int unsigned P_W  = A_WIDTH + B_WIDTH;
  localparam int unsigned LAST = NUM_STAGE - 1;
  localparam int unsigned MSB  = ACC_WIDTH - 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_rst_done;
  logic [NUM_STAGE-1:0]   r_vld;
  logic [NUM_STAGE-1:0]   r_acc;
  logic [NUM_STAGE-1:0]   r_last;
  logic [P_W-1:0]         r_prod [NUM_STAGE];
  logic [ACC_WIDTH-1:0]   r_sum;
  logic                   r_flag;
  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_dout;
  logic                   r_ovf;

  logic                   w_stall;
  logic                   w_accept;
  logic                   w_retire;
  logic                   w_a_sx;
  logic                   w_b_sx;
  logic                   w_p_sx;
  logic [P_W-1:0]         w_a_ext;
  logic [P_W-1:0]         w_b_ext;
  logic [P_W-1:0]         w_prod;
  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   w_base;
  logic [ACC_WIDTH:0]     w_sum_wide;
  logic [ACC_WIDTH-1:0]   w_add;
  logic                   w_add_ovf;
  logic                   w_flag;
  logic [ACC_WIDTH-1:0]   w_sum_nxt;
  logic                   w_flag_nxt;
  logic                   w_emit;
  logic                   w_out_valid_nxt;
  logic [ACC_WIDTH-1:0]   w_dout_nxt;
  logic                   w_ovf_nxt;

  // in_ready stays low until the first edge after reset release
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = r_rst_done && !w_stall;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_vld[LAST] && !w_stall;

  // Operands extended to full product width so one unsigned multiply serves both modes
  assign w_a_sx  = (SIGNED != 0) && din0[A_WIDTH-1];
  assign w_b_sx  = (SIGNED != 0) && din1[B_WIDTH-1];
  assign w_a_ext = {{B_WIDTH{w_a_sx}}, din0};
  assign w_b_ext = {{A_WIDTH{w_b_sx}}, din1};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_p_sx = (SIGNED != 0) && r_prod[LAST][P_W-1];
  generate
    if (ACC_WIDTH > P_W) begin : g_ext
      assign w_prod_ext = {{(ACC_WIDTH - P_W){w_p_sx}}, r_prod[LAST]};
    end else begin : g_noext
      assign w_prod_ext = r_prod[LAST];
    end
  endgenerate

  // Group add: IDLE starts from zero, overflow judged per operand signedness
  assign w_base     = (r_state == ST_RUN) ? r_sum : '0;
  assign w_sum_wide = {1'b0, w_base} + {1'b0, w_prod_ext};
  assign w_add      = w_sum_wide[MSB:0];
  assign w_add_ovf  = (SIGNED != 0)
                    ? ((w_base[MSB] == w_prod_ext[MSB]) && (w_add[MSB] != w_base[MSB]))
                    : w_sum_wide[ACC_WIDTH];
  assign w_flag     = ((r_state == ST_RUN) && r_flag) || w_add_ovf;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld  <= '0;
      r_acc  <= '0;
      r_last <= '0;
      for (int i = 0; i < int'(NUM_STAGE); i++) r_prod[i] <= '0;
    end else if (!w_stall) begin
      r_vld[0]  <= w_accept;
      r_acc[0]  <= acc_en;
      r_last[0] <= in_last && acc_en;
      r_prod[0] <= w_prod;
      for (int i = 1; i < int'(NUM_STAGE); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_acc[i]  <= r_acc[i-1];
        r_last[i] <= r_last[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  // Accumulator FSM next-state and output-register loads
  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_flag_nxt  = r_flag;
    w_emit      = 1'b0;
    w_dout_nxt  = r_dout;
    w_ovf_nxt   = r_ovf;
    if (w_retire) begin
      if (!r_acc[LAST]) begin
        w_emit     = 1'b1;
        w_dout_nxt = w_prod_ext;
        w_ovf_nxt  = 1'b0;
      end else if (r_last[LAST]) begin
        w_emit      = 1'b1;
        w_dout_nxt  = w_add;
        w_ovf_nxt   = w_flag;
        w_sum_nxt   = '0;
        w_flag_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end else begin
        w_sum_nxt   = w_add;
        w_flag_nxt  = w_flag;
        w_state_nxt = ST_RUN;
      end
    end
    w_out_valid_nxt = w_stall ? 1'b1 : w_emit;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= ST_IDLE;
      r_rst_done  <= 1'b0;
      r_sum       <= '0;
      r_flag      <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rst_done  <= 1'b1;
      r_sum       <= w_sum_nxt;
      r_flag      <= w_flag_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_dout      <= w_dout_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cnna_mac_pipe.sv
// Bench for cnna_mac_pipe: three configurations (default, 31-bit acc, signed) share one stimulus
// stream; per-instance expected results are queued on acceptance and popped on output handshake.
module tb_cnna_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, acc_en, in_last;
  logic [17:0] din0;
  logic [12:0] din1;
  logic        man_rdy, rnd_rdy, bp_en;
  logic        out_ready;
  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        ovf0, ovf1, ovf2;
  logic [39:0] dout0;
  logic [30:0] dout1;
  logic [39:0] dout2;

  always #5 clk = ~clk;
  assign out_ready = bp_en ? rnd_rdy : man_rdy;
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  cnna_mac_pipe u_d0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .din0(din0), .din1(din1), .acc_en(acc_en), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .dout(dout0), .ovf(ovf0));

  cnna_mac_pipe #(.ACC_WIDTH(31)) u_d1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .din0(din0), .din1(din1), .acc_en(acc_en), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .dout(dout1), .ovf(ovf1));

  cnna_mac_pipe #(.SIGNED(1)) u_d2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .din0(din0), .din1(din1), .acc_en(acc_en), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .dout(dout2), .ovf(ovf2));

  typedef struct packed {
    logic [17:0] a;
    logic [12:0] b;
    logic        acc;
    logic        last;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] e2;
    logic        o0;
    logic        o1;
    logic        o2;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic        o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t tbl[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic        p_stall = 1'b0;
  logic [39:0] p_dout;
  logic        p_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output with no expected result queued at %0t", name, $time);
  endtask

  function automatic vec_t mk(input logic [17:0] a, input logic [12:0] b, input logic acc,
                              input logic last, input logic [63:0] e0, input logic [63:0] e1,
                              input logic [63:0] e2, input logic o0, input logic o1,
                              input logic o2);
    vec_t v;
    v.a = a; v.b = b; v.acc = acc; v.last = last;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.o0 = o0; v.o1 = o1; v.o2 = o2;
    return v;
  endfunction

  // Small positive operands give identical results in all three configurations
  function automatic vec_t mks(input logic [17:0] a, input logic [12:0] b, input logic acc,
                               input logic last, input logic [63:0] e);
    return mk(a, b, acc, last, e, e, e, 1'b0, 1'b0, 1'b0);
  endfunction

  // Output monitor: scoreboard pops plus hold-while-stalled check on instance 0
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (ov0 && out_ready) begin
        if (q0.size() == 0) unexpected("d0 out");
        else begin
          e_mon = q0.pop_front();
          chk("d0 dout", 64'(dout0), e_mon.d);
          chk("d0 ovf", 64'(ovf0), 64'(e_mon.o));
        end
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) unexpected("d1 out");
        else begin
          e_mon = q1.pop_front();
          chk("d1 dout", 64'(dout1), e_mon.d);
          chk("d1 ovf", 64'(ovf1), 64'(e_mon.o));
        end
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) unexpected("d2 out");
        else begin
          e_mon = q2.pop_front();
          chk("d2 dout", 64'(dout2), e_mon.d);
          chk("d2 ovf", 64'(ovf2), 64'(e_mon.o));
        end
      end
      if (p_stall) begin
        chk("hold out_valid", 64'(ov0), 64'd1);
        chk("hold dout", 64'(dout0), 64'(p_dout));
        chk("hold ovf", 64'(ovf0), 64'(p_ovf));
      end
      p_stall = ov0 && !out_ready;
      p_dout  = dout0;
      p_ovf   = ovf0;
    end
  end

  // Present one beat from posedge+1 until accepted; queue its results if it emits
  task automatic send(input vec_t v);
    logic ok;
    ok = 1'b0;
    din0 = v.a; din1 = v.b; acc_en = v.acc; in_last = v.last; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      unexpected("send timeout");
    end else begin
      chk("d1 in_ready", 64'(rdy1), 64'd1);
      chk("d2 in_ready", 64'(rdy2), 64'd1);
      if (!v.acc || v.last) begin
        q0.push_back({v.e0, v.o0});
        q1.push_back({v.e1, v.o1});
        q2.push_back({v.e2, v.o2});
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 500; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk(name, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v_big;
    int   lat;
    rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0; man_rdy = 1'b1; bp_en = 1'b0;

    tbl.push_back(mks(18'd5, 13'd7, 1'b0, 1'b0, 64'd35));
    tbl.push_back(mks(18'd0, 13'd123, 1'b0, 1'b0, 64'd0));
    tbl.push_back(mks(18'd2, 13'd3, 1'b1, 1'b0, 64'd0));
    tbl.push_back(mks(18'd4, 13'd5, 1'b1, 1'b0, 64'd0));
    tbl.push_back(mks(18'd6, 13'd7, 1'b1, 1'b1, 64'd68));
    tbl.push_back(mks(18'd9, 13'd9, 1'b1, 1'b1, 64'd81));
    tbl.push_back(mks(18'd10, 13'd10, 1'b1, 1'b0, 64'd0));
    tbl.push_back(mks(18'd3, 13'd3, 1'b0, 1'b0, 64'd9));
    tbl.push_back(mks(18'd1, 13'd2, 1'b1, 1'b1, 64'd102));
    tbl.push_back(mks(18'd1, 13'd1, 1'b1, 1'b0, 64'd0));
    tbl.push_back(mks(18'd2, 13'd2, 1'b0, 1'b1, 64'd4));
    tbl.push_back(mks(18'd3, 13'd1, 1'b1, 1'b1, 64'd4));
    tbl.push_back(mks(18'd100000, 13'd4000, 1'b0, 1'b0, 64'd400000000));
    tbl.push_back(mk(18'h3FFFF, 13'h1FFF, 1'b0, 1'b0,
                     64'h7FFBE001, 64'h7FFBE001, 64'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(18'h3FFFF, 13'h1FFF, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(18'h3FFFF, 13'h1FFF, 1'b1, 1'b1,
                     64'hFFF7C002, 64'h7FF7C002, 64'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(18'h3FFFF, 13'h1000, 1'b1, 1'b1,
                     64'h3FFFF000, 64'h3FFFF000, 64'd4096, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(18'h3FFFE, 13'd3, 1'b0, 1'b0,
                     64'hBFFFA, 64'hBFFFA, 64'hFF_FFFF_FFFA, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(18'h3FFFF, 13'h1000, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(18'h3FFFE, 13'd3, 1'b1, 1'b1,
                     64'h400BEFFA, 64'h400BEFFA, 64'd4090, 1'b0, 1'b0, 1'b0));

    // Reset values, then in_ready only after the first edge following release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(ov0), 64'd0);
    chk("rst dout", 64'(dout0), 64'd0);
    chk("rst ovf", 64'(ovf0), 64'd0);
    chk("rst in_ready", 64'(rdy0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready before edge", 64'(rdy0), 64'd0);
    @(negedge clk);
    chk("in_ready after edge", 64'(rdy0), 64'd1);
    @(posedge clk);
    #1;

    // Latency from acceptance to out_valid
    v_big = mk(18'h3FFFF, 13'h1FFF, 1'b0, 1'b0, 64'h7FFBE001, 64'h7FFBE001, 64'd1,
               1'b0, 1'b0, 1'b0);
    send(v_big);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ov0) begin
        lat = i;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd4);
    wait_drain("drain latency");

    foreach (tbl[i]) send(tbl[i]);
    wait_drain("drain table");

    bp_en = 1'b1;
    foreach (tbl[i]) send(tbl[i]);
    wait_drain("drain table backpressure");
    bp_en = 1'b0;

    // Long downstream stall with continuous input
    man_rdy = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(mks(18'(i), 13'd3, 1'b0, 1'b0, 64'(3 * i)));
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (ov0) break;
        end
        repeat (10) @(negedge clk);
        chk("stall in_ready", 64'(rdy0), 64'd0);
        chk("stall out_valid", 64'(ov0), 64'd1);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
      end
    join
    wait_drain("drain stall");

    // Reset mid-group discards the partial sum
    send(mks(18'd5, 13'd5, 1'b1, 1'b0, 64'd0));
    send(mks(18'd6, 13'd6, 1'b1, 1'b0, 64'd0));
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst out_valid", 64'(ov0), 64'd0);
    chk("midrst dout", 64'(dout0), 64'd0);
    chk("midrst ovf", 64'(ovf0), 64'd0);
    chk("midrst in_ready", 64'(rdy0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mks(18'd1, 13'd1, 1'b1, 1'b1, 64'd1));
    wait_drain("drain after reset");
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
